pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic elastic pipeline-stage register; successor to the fixed EX/MEM latch.
//  Carries CTRL_W control bits and DATA_W payload bits with a valid/ready handshake,
//  synchronous flush and an optional skid slot, so stages can stall and flush
//  independently. It can replace any of the IF/ID, ID/EX, EX/MEM or MEM/WB latches.
// PARAMETERS
//  CTRL_W  4   control bits (RegWrite, MemtoReg, ...); forced to 0 whenever out_valid=0
//  DATA_W  101 payload bits (alu_result, rs2_data, rd, pc_plus4 concatenated)
//  SKID    1   1: two-entry skid buffer, registered in_ready; 0: single entry, comb in_ready
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       synchronous kill of all held entries (branch/exception)
//  in_valid   in   1       upstream has an entry
//  in_ready   out  1       stage accepts this cycle
//  in_ctrl    in   CTRL_W  control bits of incoming entry
//  in_data    in   DATA_W  payload of incoming entry
//  out_valid  out  1       main slot holds a live entry
//  out_ready  in   1       downstream accepts this cycle
//  out_ctrl   out  CTRL_W  control bits; all 0 when out_valid=0 (bubble)
//  out_data   out  DATA_W  payload; holds its value while stalled
//  occupancy  out  2       live entries held: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset: out_valid=0, out_ctrl=0, out_data=0, skid slot empty/zeroed, occupancy=0,
//    in_ready=1 from the first cycle after reset deasserts.
//  - Accept = in_valid & in_ready; release = out_valid & out_ready. Latency 1 cycle.
//  - Occupancy FSM: EMPTY -> FULL on accept. FULL: accept & release -> FULL (main reloads);
//    release only -> EMPTY; accept only -> SKID_FULL (SKID=1, entry goes to skid slot).
//    SKID_FULL: release -> FULL (skid moves to main); in_ready=0 so no accept.
//  - SKID=1: in_ready = (state != SKID_FULL), registered (no comb path out_ready->in_ready).
//    Sustains 1 entry/cycle; order preserved (skid entry always leaves before newer ones).
//  - SKID=0: in_ready = ~out_valid | out_ready (comb); SKID_FULL unreachable.
//  - Stall (out_ready=0 while out_valid=1): out_ctrl/out_data stable until release.
//  - flush=1: next state EMPTY, out_ctrl=0, both slots invalid. Flush beats a same-cycle
//    accept (incoming entry dropped) and a same-cycle release (release still counts
//    downstream that cycle, since out_valid was 1). in_ready is 1 on the cycle after flush.
//  - Payload data of invalid slots is don't-care, except out_data=0 straight after reset.
//  - Async reset mid-transfer: all state cleared immediately; in-flight entries lost.
// STRUCTURE
//  - pipe_pkg: occ_state_e {OCC_EMPTY, OCC_FULL, OCC_SKID_FULL}, reset-value constants.
//  - One sub-module, pipe_slot (valid + ctrl + data register with load/clear), used
//    twice (main, skid). The skid instance is generated only when SKID=1.
//  - Top level holds the occupancy FSM, mux of skid/in_data into the main slot,
//    and the in_ready/occupancy logic.
// TESTING
//  1 Reset: assert reset mid-cycle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
//  2 Streaming: out_ready=1, 8 back-to-back entries data=1..8 -> out_data 1..8 on
//    consecutive cycles, 1-cycle latency, in_ready stays 1.
//  3 Stall (SKID=1): send A,B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A held;
//    raise out_ready -> A then B, then in_ready=1.
//  4 Bubble: in_valid=0 with in_ctrl=4'hF -> out_valid=0 and out_ctrl=0 next cycle.
//  5 Flush: occupancy=2, then flush=1 with in_valid=1 (data C) -> next cycle occupancy=0,
//    out_ctrl=0, C never appears at the output.
//  6 SKID=0 build: out_ready=0 & out_valid=1 -> in_ready=0 in the same cycle; accept and
//    release in the same cycle -> new entry replaces the old one with no bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// Occupancy states and their reset values live here so top and bench agree.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY     = 2'd0,
    OCC_FULL      = 2'd1,
    OCC_SKID_FULL = 2'd2
  } occ_state_e;

  localparam occ_state_e OCC_RST_STATE = OCC_EMPTY;
  localparam logic       SLOT_RST_VALID = 1'b0;

  // Number of live entries represented by an occupancy state.
  function automatic logic [1:0] occ_count(input occ_state_e s);
    case (s)
      OCC_FULL:      occ_count = 2'd1;
      OCC_SKID_FULL: occ_count = 2'd2;
      default:       occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus control and payload registers.
// Clear wins over load and zeroes valid and ctrl; payload keeps its last value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= SLOT_RST_VALID;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= load_valid;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and optional skid slot.
//   state         | meaning
//   OCC_EMPTY     | no live entry, in_ready=1
//   OCC_FULL      | main slot live, skid slot empty
//   OCC_SKID_FULL | main and skid slots live, in_ready=0 (SKID=1 only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_state_e state, state_nxt;

  logic acc, rel;
  logic main_load, main_clear, main_sel_skid;
  logic skid_load, skid_clear;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_in_valid;
  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign acc = in_valid & in_ready;
  assign rel = main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OCC_RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (acc) begin
          state_nxt = OCC_FULL;
          main_load = 1'b1;
        end
      end
      OCC_FULL: begin
        if (acc && rel) begin
          main_load = 1'b1;
        end else if (rel) begin
          state_nxt  = OCC_EMPTY;
          main_clear = 1'b1;
        end else if (acc && SKID != 0) begin
          state_nxt = OCC_SKID_FULL;
          skid_load = 1'b1;
        end
      end
      OCC_SKID_FULL: begin
        if (rel) begin
          state_nxt     = OCC_FULL;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_clear    = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    // Flush drops any same-cycle accept; a same-cycle release has already happened.
    if (flush) begin
      state_nxt  = OCC_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  assign main_in_valid = main_sel_skid ? skid_valid : 1'b1;
  assign main_in_ctrl  = main_sel_skid ? skid_ctrl  : in_ctrl;
  assign main_in_data  = main_sel_skid ? skid_data  : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (main_load),
    .clear      (main_clear),
    .load_valid (main_in_valid),
    .load_ctrl  (main_in_ctrl),
    .load_data  (main_in_data),
    .valid      (main_valid),
    .ctrl       (main_ctrl),
    .data       (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_valid (1'b1),
        .load_ctrl  (in_ctrl),
        .load_data  (in_data),
        .valid      (skid_valid),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
      );
      // Derived from the state register only, so out_ready never reaches in_ready.
      assign in_ready = (state != OCC_SKID_FULL);
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;
  assign occupancy = occ_count(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances checked against queue models.
// Directed scenarios first, then randomized traffic with occasional flushes.
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 101;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  logic          in_valid_a = 0, in_ready_a, out_valid_a, out_ready_a = 0;
  logic [CW-1:0] in_ctrl_a = '0, out_ctrl_a;
  logic [DW-1:0] in_data_a = '0, out_data_a;
  logic [1:0]    occupancy_a;

  logic          in_valid_b = 0, in_ready_b, out_valid_b, out_ready_b = 1;
  logic [CW-1:0] in_ctrl_b = '0, out_ctrl_b;
  logic [DW-1:0] in_data_b = '0, out_data_b;
  logic [1:0]    occupancy_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_ctrl(in_ctrl_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_ctrl(out_ctrl_a),
    .out_data(out_data_a), .occupancy(occupancy_a)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_ctrl(in_ctrl_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .occupancy(occupancy_b)
  );

  // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  ent_t qa[$];
  ent_t qb[$];
  logic acc_a, rel_a, acc_b, rel_b;

  function automatic logic exp_rdy_a();
    return qa.size() < 2;
  endfunction

  function automatic logic exp_rdy_b();
    return (qb.size() == 0) || out_ready_b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      acc_a = in_valid_a && exp_rdy_a();
      rel_a = (qa.size() > 0) && out_ready_a;
      acc_b = in_valid_b && exp_rdy_b();
      rel_b = (qb.size() > 0) && out_ready_b;
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (rel_a) void'(qa.pop_front());
        if (acc_a) qa.push_back({in_ctrl_a, in_data_a});
        if (rel_b) void'(qb.pop_front());
        if (acc_b) qb.push_back({in_ctrl_b, in_data_b});
      end
    end
  end

  function automatic ent_t rnd_ent();
    logic [127:0] r;
    ent_t e;
    r = {$urandom, $urandom, $urandom, $urandom};
    e.d = r[DW-1:0];
    e.c = r[CW-1:0] ^ 4'($urandom);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ent_t e;
    in_valid_a = 1; out_ready_a = 0;
    for (int i = 0; i < 2; i++) begin
      e = rnd_ent(); in_ctrl_a = e.c; in_data_a = e.d;
      tick();
    end
    in_valid_a = 0;
    #2 reset = 1;
    #1;
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_a); end
    total++; if (out_ctrl_a !== '0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl_a); end
    total++; if (out_data_a !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data_a); end
    total++; if (occupancy_a !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy_a); end
    @(negedge clk);
    reset = 0;
    tick();
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_rdy_a got=%b exp=1", in_ready_a); end
    total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL reset_rdy_b got=%b exp=1", in_ready_b); end
    total++; if (out_valid_b !== 1'b0 || out_data_b !== '0) begin
      bad++; $display("FAIL reset_b got=%b/%h exp=0/0", out_valid_b, out_data_b);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    out_ready_a = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_a = 1; in_data_a = DW'(i); in_ctrl_a = CW'(i);
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL stream_rdy i=%0d got=%b exp=1", i, in_ready_a); end
      tick();
      exp_d = DW'(i);
      total++; if (out_valid_a !== 1'b1 || out_data_a !== exp_d) begin
        bad++; $display("FAIL stream_out i=%0d got=%b/%0d exp=1/%0d", i, out_valid_a, out_data_a, i);
      end
    end
    in_valid_a = 0;
    tick();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_stall();
    ent_t a, b;
    a = rnd_ent(); b = rnd_ent();
    out_ready_a = 0;
    in_valid_a = 1; in_ctrl_a = a.c; in_data_a = a.d;
    tick();
    in_ctrl_a = b.c; in_data_a = b.d;
    tick();
    in_valid_a = 0;
    for (int k = 0; k < 2; k++) begin
      total++; if (occupancy_a !== 2'd2) begin bad++; $display("FAIL stall_occ got=%0d exp=2", occupancy_a); end
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL stall_rdy got=%b exp=0", in_ready_a); end
      total++; if (out_data_a !== a.d || out_ctrl_a !== a.c) begin
        bad++; $display("FAIL stall_hold got=%h exp=%h", out_data_a, a.d);
      end
      tick();
    end
    out_ready_a = 1;
    tick();
    total++; if (out_valid_a !== 1'b1 || out_data_a !== b.d) begin
      bad++; $display("FAIL stall_second got=%h exp=%h", out_data_a, b.d);
    end
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL stall_rdy_after got=%b exp=1", in_ready_a); end
    tick();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_bubble();
    out_ready_a = 1;
    in_valid_a = 1; in_ctrl_a = 4'h5; in_data_a = DW'(77);
    tick();
    in_valid_a = 0; in_ctrl_a = 4'hF;
    tick();
    total++; if (out_valid_a !== 1'b0 || out_ctrl_a !== 4'h0) begin
      bad++; $display("FAIL bubble got=%b/%h exp=0/0", out_valid_a, out_ctrl_a);
    end
  endtask

  task automatic test_flush();
    ent_t c;
    out_ready_a = 0; in_valid_a = 1;
    for (int i = 0; i < 2; i++) begin
      in_ctrl_a = 4'hA; in_data_a = DW'(100 + i);
      tick();
    end
    total++; if (occupancy_a !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy_a); end
    c = rnd_ent(); c.c = 4'hC;
    in_ctrl_a = c.c; in_data_a = c.d; flush = 1;
    tick();
    flush = 0; in_valid_a = 0; out_ready_a = 1;
    total++; if (occupancy_a !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy_a); end
    total++; if (out_ctrl_a !== 4'h0) begin bad++; $display("FAIL flush_ctrl got=%h exp=0", out_ctrl_a); end
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL flush_rdy got=%b exp=1", in_ready_a); end
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid_a !== 1'b0) begin
        bad++; $display("FAIL flush_leak k=%0d got=%b/%h exp=0", k, out_valid_a, out_data_a);
      end
      tick();
    end
  endtask

  task automatic test_noskid();
    ent_t x, y;
    x = rnd_ent(); y = rnd_ent();
    in_valid_b = 1; in_ctrl_b = x.c; in_data_b = x.d; out_ready_b = 0;
    tick();
    total++; if (out_valid_b !== 1'b1 || out_data_b !== x.d) begin
      bad++; $display("FAIL noskid_load got=%b/%h exp=1/%h", out_valid_b, out_data_b, x.d);
    end
    in_ctrl_b = y.c; in_data_b = y.d;
    #1;
    total++; if (in_ready_b !== 1'b0) begin bad++; $display("FAIL noskid_stall_rdy got=%b exp=0", in_ready_b); end
    tick();
    total++; if (out_data_b !== x.d || occupancy_b !== 2'd1) begin
      bad++; $display("FAIL noskid_hold got=%h/%0d exp=%h/1", out_data_b, occupancy_b, x.d);
    end
    out_ready_b = 1;
    #1;
    total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL noskid_comb_rdy got=%b exp=1", in_ready_b); end
    tick();
    total++; if (out_valid_b !== 1'b1 || out_data_b !== y.d || out_ctrl_b !== y.c) begin
      bad++; $display("FAIL noskid_replace got=%b/%h exp=1/%h", out_valid_b, out_data_b, y.d);
    end
    in_valid_b = 0;
    tick();
    total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL noskid_drain got=%b exp=0", out_valid_b); end
  endtask

  task automatic test_random();
    ent_t e;
    logic [CW-1:0] ec;
    for (int n = 0; n < 400; n++) begin
      e = rnd_ent();
      in_valid_a = ($urandom_range(0, 9) < 7); in_ctrl_a = e.c; in_data_a = e.d;
      out_ready_a = ($urandom_range(0, 9) < 6);
      e = rnd_ent();
      in_valid_b = ($urandom_range(0, 9) < 7); in_ctrl_b = e.c; in_data_b = e.d;
      out_ready_b = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      total++; if (in_ready_a !== exp_rdy_a() || in_ready_b !== exp_rdy_b()) begin
        bad++; $display("FAIL rnd_rdy n=%0d got=%b%b exp=%b%b", n, in_ready_a, in_ready_b, exp_rdy_a(), exp_rdy_b());
      end
      tick();
      ec = (qa.size() > 0) ? qa[0].c : '0;
      total++; if (out_valid_a !== (qa.size() > 0) || out_ctrl_a !== ec || occupancy_a !== 2'(qa.size())) begin
        bad++; $display("FAIL rnd_a n=%0d got=%b/%h/%0d exp=%b/%h/%0d", n, out_valid_a, out_ctrl_a,
                        occupancy_a, qa.size() > 0, ec, qa.size());
      end
      if (qa.size() > 0) begin
        total++; if (out_data_a !== qa[0].d) begin
          bad++; $display("FAIL rnd_a_data n=%0d got=%h exp=%h", n, out_data_a, qa[0].d);
        end
      end
      ec = (qb.size() > 0) ? qb[0].c : '0;
      total++; if (out_valid_b !== (qb.size() > 0) || out_ctrl_b !== ec || occupancy_b !== 2'(qb.size())) begin
        bad++; $display("FAIL rnd_b n=%0d got=%b/%h/%0d exp=%b/%h/%0d", n, out_valid_b, out_ctrl_b,
                        occupancy_b, qb.size() > 0, ec, qb.size());
      end
      if (qb.size() > 0) begin
        total++; if (out_data_b !== qb[0].d) begin
          bad++; $display("FAIL rnd_b_data n=%0d got=%h exp=%h", n, out_data_b, qb[0].d);
        end
      end
    end
    flush = 0; in_valid_a = 0; in_valid_b = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_noskid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
